mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-ported memory slave (a `tcm` instance) between the `pipeline` instruction port and its data port, for configurations where ITCM and DTCM are merged. It uses a registered round-robin grant state machine, holds the grant for a whole transaction and passes the granted master's command through to the slave. Each master sees a standard waitrequest-style slave port, so `pipeline` connects unchanged.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory slave
// between the instruction and data ports of the pipeline.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_rd,
  output logic [DATA_WIDTH-1:0]   i_rd_data,
  output logic                    i_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_rd,
  input  logic                    d_wr,
  input  logic [DATA_WIDTH-1:0]   d_wr_data,
  input  logic [DATA_WIDTH/8-1:0] d_wr_be,
  output logic [DATA_WIDTH-1:0]   d_rd_data,
  output logic                    d_waitrequest,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] mem_wr_be,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  input  logic                    mem_waitrequest
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last;
  logic       last_nxt;
  logic       i_req;
  logic       d_req;
  logic       done;

  assign i_req = i_rd;
  assign d_req = d_rd | d_wr;
  assign done  = (mem_rd | mem_wr) & ~mem_waitrequest;

  // last = 1 means D was served last, so I wins the next tie
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (i_req && d_req)
          state_nxt = last ? GNT_I : GNT_D;
        else if (i_req)
          state_nxt = GNT_I;
        else if (d_req)
          state_nxt = GNT_D;
      end
      GNT_I: begin
        if (!i_req) begin
          state_nxt = IDLE;
        end else if (done) begin
          last_nxt  = 1'b0;
          state_nxt = d_req ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        if (!d_req) begin
          state_nxt = IDLE;
        end else if (done) begin
          last_nxt  = 1'b1;
          state_nxt = i_req ? GNT_I : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command mux is purely a function of state so reset kills it at once
  always_comb begin
    mem_addr      = '0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    mem_wr_data   = '0;
    mem_wr_be     = {BE_WIDTH{1'b0}};
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (state)
      GNT_I: begin
        mem_addr      = i_addr;
        mem_rd        = i_rd;
        i_waitrequest = mem_waitrequest;
      end
      GNT_D: begin
        mem_addr      = d_addr;
        mem_rd        = d_rd;
        mem_wr        = d_wr;
        mem_wr_data   = d_wr_data;
        mem_wr_be     = d_wr_be;
        d_waitrequest = mem_waitrequest;
      end
      default: ;
    endcase
  end

  assign i_rd_data = mem_rd_data;
  assign d_rd_data = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a wait-state capable
// memory slave model and bus-level master tasks.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic [3:0]  be;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] i_addr;
  logic        i_rd;
  logic [31:0] i_rd_data;
  logic        i_waitrequest;
  logic [31:0] d_addr;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_wr_data;
  logic [3:0]  d_wr_be;
  logic [31:0] d_rd_data;
  logic        d_waitrequest;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic [31:0] mem_rd_data;
  logic        mem_waitrequest;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ws     = 0;
  int wcnt;
  int t0;

  logic [31:0] smem    [256];
  logic [31:0] ref_mem [256];

  exp_t i_exp [$];
  exp_t d_exp [$];
  int   log_who [$];
  int   log_cyc [$];

  mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .i_addr          (i_addr),
    .i_rd            (i_rd),
    .i_rd_data       (i_rd_data),
    .i_waitrequest   (i_waitrequest),
    .d_addr          (d_addr),
    .d_rd            (d_rd),
    .d_wr            (d_wr),
    .d_wr_data       (d_wr_data),
    .d_wr_be         (d_wr_be),
    .d_rd_data       (d_rd_data),
    .d_waitrequest   (d_waitrequest),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_be       (mem_wr_be),
    .mem_rd_data     (mem_rd_data),
    .mem_waitrequest (mem_waitrequest)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Slave model: ws wait states per access, then completes
  assign mem_waitrequest = (mem_rd | mem_wr) && (wcnt < ws);
  assign mem_rd_data     = smem[mem_addr[9:2]];

  always @(posedge clock or posedge reset) begin
    if (reset)
      wcnt <= 0;
    else if ((mem_rd | mem_wr) && mem_waitrequest)
      wcnt <= wcnt + 1;
    else
      wcnt <= 0;
  end

  always @(posedge clock) begin
    if (!reset && mem_wr && !mem_waitrequest)
      for (int b = 0; b < 4; b++)
        if (mem_wr_be[b])
          smem[mem_addr[9:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Completion monitor pops the scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (!reset && i_rd && !i_waitrequest) begin
      log_who.push_back(0);
      log_cyc.push_back(cyc);
      chk("i_sb_size", i_exp.size() > 0, 1);
      if (i_exp.size() > 0) begin
        e = i_exp.pop_front();
        chk("i_rd_data", i_rd_data, e.data);
        chk("i_mem_addr", mem_addr, e.addr);
        chk("i_mem_wr", mem_wr, 0);
        chk("i_mem_be", mem_wr_be, 0);
      end
    end
    if (!reset && (d_rd || d_wr) && !d_waitrequest) begin
      log_who.push_back(1);
      log_cyc.push_back(cyc);
      chk("d_sb_size", d_exp.size() > 0, 1);
      if (d_exp.size() > 0) begin
        e = d_exp.pop_front();
        chk("d_mem_addr", mem_addr, e.addr);
        if (e.rd) begin
          chk("d_rd_data", d_rd_data, e.data);
          chk("d_mem_rd", mem_rd, 1);
        end else begin
          chk("d_mem_wr", mem_wr, 1);
          chk("d_wr_data", mem_wr_data, e.data);
          chk("d_wr_be", mem_wr_be, e.be);
        end
      end
    end
  end

  task automatic i_access(input logic [31:0] a);
    bit done = 0;
    i_exp.push_back('{a, ref_mem[a[9:2]], 1'b1, 4'h0});
    i_addr = a;
    i_rd   = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      done = !i_waitrequest;
      @(posedge clock);
      #1;
    end
    i_rd = 1'b0;
    chk("i_done", done, 1);
  endtask

  task automatic d_access(input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    bit done = 0;
    if (rd) begin
      d_exp.push_back('{a, ref_mem[a[9:2]], 1'b1, 4'h0});
    end else begin
      d_exp.push_back('{a, wd, 1'b0, be});
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
    end
    d_addr    = a;
    d_rd      = rd;
    d_wr      = !rd;
    d_wr_data = wd;
    d_wr_be   = be;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      done = !d_waitrequest;
      @(posedge clock);
      #1;
    end
    d_rd = 1'b0;
    d_wr = 1'b0;
    chk("d_done", done, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) begin
      smem[k]    = {8'hA5, 8'(k), 16'(k * 37)};
      ref_mem[k] = {8'hA5, 8'(k), 16'(k * 37)};
    end
    reset     = 1'b1;
    i_addr    = 32'h123;
    i_rd      = 1'b0;
    d_addr    = 32'hFFFF_FFFC;
    d_rd      = 1'b0;
    d_wr      = 1'b0;
    d_wr_data = 32'hFFFF_FFFF;
    d_wr_be   = 4'hF;

    // reset state, with junk on idle master inputs
    @(negedge clock);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_wr_be", mem_wr_be, 0);
    chk("rst_i_wait", i_waitrequest, 1);
    chk("rst_d_wait", d_waitrequest, 1);
    @(posedge clock); #1 reset = 1'b0;

    // single I read, zero wait
    @(posedge clock); #1;
    i_exp.push_back('{32'h100, ref_mem[32'h100 >> 2], 1'b1, 4'h0});
    i_addr = 32'h100;
    i_rd   = 1'b1;
    @(negedge clock);
    chk("t1_c0_i_wait", i_waitrequest, 1);
    chk("t1_c0_mem_rd", mem_rd, 0);
    @(negedge clock);
    chk("t1_c1_mem_rd", mem_rd, 1);
    chk("t1_c1_addr", mem_addr, 32'h100);
    chk("t1_c1_i_wait", i_waitrequest, 0);
    @(posedge clock); #1 i_rd = 1'b0;

    // simultaneous after reset: I first, then D write
    pulse_reset();
    log_who.delete(); log_cyc.delete();
    t0 = cyc;
    fork
      i_access(32'h0);
      d_access(1'b0, 32'h200, 32'h1234_5678, 4'b0011);
    join
    chk("t2_log_n", log_who.size(), 2);
    if (log_who.size() == 2) begin
      chk("t2_who0", log_who[0], 0);
      chk("t2_cyc0", log_cyc[0], t0 + 1);
      chk("t2_who1", log_who[1], 1);
      chk("t2_cyc1", log_cyc[1], t0 + 2);
    end

    // continuous contention: strict alternation, no bubbles
    log_who.delete(); log_cyc.delete();
    t0 = cyc;
    fork
      for (int k = 0; k < 5; k++)
        i_access(32'h40 + 32'(4 * k));
      for (int k = 0; k < 5; k++)
        d_access(k[0], 32'h300 + 32'(4 * k),
                 32'hC0DE_0000 + 32'(k), 4'hF);
    join
    chk("t3_log_n", log_who.size(), 10);
    for (int k = 0; k < log_who.size(); k++) begin
      chk($sformatf("t3_who%0d", k), log_who[k], k % 2);
      chk($sformatf("t3_cyc%0d", k), log_cyc[k], t0 + 1 + k);
    end
    d_access(1'b1, 32'h200, 32'h0, 4'h0);

    // three slave wait states on a D read, I pending
    ws = 3;
    @(posedge clock); #1;
    d_exp.push_back('{32'h314, ref_mem[32'h314 >> 2], 1'b1, 4'h0});
    d_addr = 32'h314;
    d_rd   = 1'b1;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          chk($sformatf("t4_d_wait%0d", k), d_waitrequest, k < 4);
          if (k >= 1)
            chk($sformatf("t4_i_wait%0d", k), i_waitrequest, 1);
        end
        @(posedge clock); #1 d_rd = 1'b0;
      end
      begin
        @(posedge clock); #1;
        i_access(32'h80);
      end
    join
    ws = 0;

    // reset during the second wait state of an I read
    ws = 3;
    @(posedge clock); #1;
    i_addr = 32'h44;
    i_rd   = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2 chk("t5_pre_mem_rd", mem_rd, 1);
    #1 reset = 1'b1;
    #1;
    chk("t5_mem_rd", mem_rd, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_i_wait", i_waitrequest, 1);
    chk("t5_d_wait", d_waitrequest, 1);
    i_rd = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    ws = 0;
    i_exp.delete();
    log_who.delete(); log_cyc.delete();
    t0 = cyc;
    fork
      i_access(32'h48);
      d_access(1'b1, 32'h308, 32'h0, 4'h0);
    join
    chk("t5_log_n", log_who.size(), 2);
    if (log_who.size() > 0) begin
      chk("t5_who0", log_who[0], 0);
      chk("t5_cyc0", log_cyc[0], t0 + 1);
    end

    // I abandons while waiting; pending D follows via IDLE
    ws = 3;
    @(posedge clock); #1;
    i_addr = 32'h4C;
    i_rd   = 1'b1;
    @(posedge clock); #1;
    d_exp.push_back('{32'h30C, ref_mem[32'h30C >> 2], 1'b1, 4'h0});
    d_addr = 32'h30C;
    d_rd   = 1'b1;
    @(negedge clock);
    chk("t6_c1_mem_rd", mem_rd, 1);
    chk("t6_c1_addr", mem_addr, 32'h4C);
    @(posedge clock); #1 i_rd = 1'b0;
    @(negedge clock);
    chk("t6_c2_mem_rd", mem_rd, 0);
    chk("t6_c2_d_wait", d_waitrequest, 1);
    @(negedge clock);
    chk("t6_c3_mem_rd", mem_rd, 0);
    chk("t6_c3_mem_wr", mem_wr, 0);
    chk("t6_c3_d_wait", d_waitrequest, 1);
    ws = 0;
    @(negedge clock);
    chk("t6_c4_mem_rd", mem_rd, 1);
    chk("t6_c4_addr", mem_addr, 32'h30C);
    chk("t6_c4_d_wait", d_waitrequest, 0);
    @(posedge clock); #1 d_rd = 1'b0;

    // abandon leaves last alone: next tie still goes to I
    ws = 3;
    @(posedge clock); #1;
    i_addr = 32'h50;
    i_rd   = 1'b1;
    @(posedge clock);
    @(posedge clock); #1 i_rd = 1'b0;
    @(posedge clock); #1;
    ws = 0;
    log_who.delete(); log_cyc.delete();
    t0 = cyc;
    fork
      i_access(32'h54);
      d_access(1'b1, 32'h310, 32'h0, 4'h0);
    join
    chk("t7_log_n", log_who.size(), 2);
    if (log_who.size() > 0) begin
      chk("t7_who0", log_who[0], 0);
      chk("t7_cyc0", log_cyc[0], t0 + 1);
    end

    chk("end_i_sb", i_exp.size(), 0);
    chk("end_d_sb", d_exp.size(), 0);
    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
